// File: rtl/vram_writer.sv
// vram_writer: snoops CPU writes to screen memory and queues them for the
// video RAM arbiter through a 4-entry FIFO with a valid/ready handshake.
// Optional feature macro: VRAM_WRITER_TMX_EN. When defined, the whole 16K
// screen page is captured (Timex second screen / hi-colour). When undefined,
// only the 6912-byte bitmap plus attribute area is captured.
module vram_writer (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        nMREQ,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic        m128,
  input  logic [2:0]  page_ram,
  output logic        vram_we,
  output logic [14:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  input  logic        vram_ack,
  output logic [2:0]  level,
  output logic        overflow
);

  localparam logic [2:0] DEPTH = 3'd4;

  // Write qualifier and edge detection
  logic        w_wr;
  logic        w_edge;
  logic        r_wr_d;

  // Address decode
  logic        w_page_ok;
  logic        w_page;
  logic        w_off_ok;
  logic        w_hit;

  // Capture stage (one cycle between edge detection and FIFO push)
  logic        r_cap_valid;
  logic [14:0] r_cap_waddr;
  logic [7:0]  r_cap_wdata;

  // FIFO storage and control
  logic [14:0] r_mem_addr [4];
  logic [7:0]  r_mem_data [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_level;
  logic        r_overflow;

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;

  assign w_wr   = ~nMREQ & ~nWR & nRFSH;
  assign w_edge = w_wr & ~r_wr_d;

  // Decode the bus address into a screen page and an offset-range check.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_page_ok = 1'b0;
    w_page    = 1'b0;
    case (addr[15:14])
      2'b01: begin
        w_page_ok = 1'b1;
        w_page    = 1'b0;
      end
      2'b11: begin
        if (m128 && page_ram == 3'd5) begin
          w_page_ok = 1'b1;
          w_page    = 1'b0;
        end else if (m128 && page_ram == 3'd7) begin
          w_page_ok = 1'b1;
          w_page    = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef VRAM_WRITER_TMX_EN
  assign w_off_ok = 1'b1;
`else
  assign w_off_ok = (addr[13:0] < 14'h1B00);
`endif

  assign w_hit = w_edge & w_page_ok & w_off_ok;

  // Edge detector and capture register. On reset the detector follows the
  // current wr level so a strobe already active at release is not taken.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_wr_d      <= w_wr;
      r_cap_valid <= 1'b0;
      r_cap_waddr <= '0;
      r_cap_wdata <= '0;
    end else begin
      r_wr_d      <= w_wr;
      r_cap_valid <= w_hit;
      if (w_edge) begin
        r_cap_waddr <= {w_page, addr[13:0]};
        r_cap_wdata <= din;
      end
    end
  end

  assign w_push   = r_cap_valid;
  assign w_pop    = vram_we & vram_ack;
  assign w_full   = (r_level == DEPTH);
  // A push into a full FIFO is only taken when the head leaves this cycle.
  assign w_accept = w_push & (~w_full | w_pop);

  // FIFO storage; the head slot is only rewritten in the cycle it is popped,
  // which keeps the presented entry stable while the arbiter stalls.
  always_ff @(posedge clk_sys) begin
    // NOTE: the storage is reset because the head slot drives the outputs
    // directly and those must read zero out of reset.
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem_addr[r_wr_ptr] <= r_cap_waddr;
      r_mem_data[r_wr_ptr] <= r_cap_wdata;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      if (w_accept && !w_pop) begin
        r_level <= r_level + 3'd1;
      end else if (!w_accept && w_pop) begin
        r_level <= r_level - 3'd1;
      end
      if (w_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign vram_we    = (r_level != 3'd0);
  assign vram_waddr = r_mem_addr[r_rd_ptr];
  assign vram_wdata = r_mem_data[r_rd_ptr];
  assign level      = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: a decode vector table plus hand-written
// sequences for stall, overflow, full-with-pop and reset behaviour. Expected
// transfers go into a scoreboard queue when the CPU write is driven and are
// compared when the DUT hands the entry over.
module tb_vram_writer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ;
  logic        nWR;
  logic        nRFSH;
  logic        m128;
  logic [2:0]  page_ram;
  logic        vram_we;
  logic [14:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_ack;
  logic [2:0]  level;
  logic        overflow;

  vram_writer dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .addr       (addr),
    .din        (din),
    .nMREQ      (nMREQ),
    .nWR        (nWR),
    .nRFSH      (nRFSH),
    .m128       (m128),
    .page_ram   (page_ram),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_ack   (vram_ack),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [14:0] waddr;
    logic [7:0]  wdata;
  } xfer_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        m128;
    logic [2:0]  page;
    logic        rfsh_n;
    logic        exp_valid;
    logic [14:0] exp_waddr;
  } vec_t;

  xfer_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    n_xfer   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Advance one cycle. Handshakes are observed on the falling edge, before
  // the rising edge that completes them; inputs change 1ns after the rise.
  task automatic tick();
    xfer_t e;
    @(negedge clk_sys);
    if (vram_we && vram_ack) begin
      n_xfer++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected got addr=%0h data=%0h expected none", vram_waddr, vram_wdata);
      end else begin
        e = sb.pop_front();
        check("xfer_waddr", 32'(vram_waddr), 32'(e.waddr));
        check("xfer_wdata", 32'(vram_wdata), 32'(e.wdata));
      end
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_write(input logic [15:0] a, input logic [7:0] d, input logic rfsh_n);
    addr  = a;
    din   = d;
    nRFSH = rfsh_n;
    nMREQ = 1'b0;
    nWR   = 1'b0;
  endtask

  task automatic end_write();
    nMREQ = 1'b1;
    nWR   = 1'b1;
    nRFSH = 1'b1;
  endtask

  task automatic expect_xfer(input logic [14:0] wa, input logic [7:0] d);
    xfer_t e;
    e.waddr = wa;
    e.wdata = d;
    sb.push_back(e);
  endtask

  // Full CPU write cycle: strobe held for two clocks, then two idle clocks.
  task automatic write_op(input logic [15:0] a, input logic [7:0] d, input logic rfsh_n,
                          input logic exp, input logic [14:0] wa);
    if (exp) expect_xfer(wa, d);
    start_write(a, d, rfsh_n);
    tick();
    tick();
    end_write();
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
  endtask

  // Acknowledge until the FIFO empties (bounded), then check the count.
  task automatic drain(input string name, input int n_before, input int n_exp);
    int budget;
    vram_ack = 1'b1;
    budget = 40;
    while ((level != 3'd0 || sb.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_count"}, 32'(n_xfer - n_before), 32'(n_exp));
    check({name, "_level"}, 32'(level), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int n0;

    vecs[0]  = '{16'h4000, 8'hAA, 1'b0, 3'd0, 1'b1, 1'b1, 15'h0000};
    vecs[1]  = '{16'hC123, 8'h55, 1'b1, 3'd7, 1'b1, 1'b1, 15'h4123};
    vecs[2]  = '{16'hC123, 8'h55, 1'b1, 3'd3, 1'b1, 1'b0, 15'h0000};
    vecs[3]  = '{16'hC010, 8'h11, 1'b1, 3'd5, 1'b1, 1'b1, 15'h0010};
    vecs[4]  = '{16'hC010, 8'h12, 1'b0, 3'd7, 1'b1, 1'b0, 15'h0000};
    vecs[5]  = '{16'h8000, 8'h22, 1'b1, 3'd7, 1'b1, 1'b0, 15'h0000};
    vecs[6]  = '{16'h0000, 8'h33, 1'b1, 3'd5, 1'b1, 1'b0, 15'h0000};
    vecs[7]  = '{16'h5AFF, 8'h44, 1'b0, 3'd0, 1'b1, 1'b1, 15'h1AFF};
`ifdef VRAM_WRITER_TMX_EN
    vecs[8]  = '{16'h5B00, 8'h66, 1'b0, 3'd0, 1'b1, 1'b1, 15'h1B00};
    vecs[10] = '{16'h7FFF, 8'h88, 1'b0, 3'd0, 1'b1, 1'b1, 15'h3FFF};
`else
    vecs[8]  = '{16'h5B00, 8'h66, 1'b0, 3'd0, 1'b1, 1'b0, 15'h0000};
    vecs[10] = '{16'h7FFF, 8'h88, 1'b0, 3'd0, 1'b1, 1'b0, 15'h0000};
`endif
    vecs[9]  = '{16'h4005, 8'h77, 1'b0, 3'd0, 1'b0, 1'b0, 15'h0000};

    reset    = 1'b1;
    addr     = '0;
    din      = '0;
    nMREQ    = 1'b1;
    nWR      = 1'b1;
    nRFSH    = 1'b1;
    m128     = 1'b0;
    page_ram = 3'd0;
    vram_ack = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_waddr", 32'(vram_waddr), 32'd0);
    check("rst_wdata", 32'(vram_wdata), 32'd0);

    // Decode table, ack held high
    vram_ack = 1'b1;
    for (int i = 0; i < 11; i++) begin
      m128     = vecs[i].m128;
      page_ram = vecs[i].page;
      n0       = n_xfer;
      write_op(vecs[i].addr, vecs[i].data, vecs[i].rfsh_n, vecs[i].exp_valid, vecs[i].exp_waddr);
      tick();
      tick();
      check($sformatf("vec%0d_xfers", i), 32'(n_xfer - n0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_level", i), 32'(level), 32'd0);
    end
    m128     = 1'b0;
    page_ram = 3'd0;

    // Latency and stall stability with ack low
    vram_ack = 1'b0;
    n0 = n_xfer;
    expect_xfer(15'h0123, 8'h5A);
    start_write(16'h4123, 8'h5A, 1'b1);
    tick();
    tick();
    check("lat_we", 32'(vram_we), 32'd1);
    check("lat_level", 32'(level), 32'd1);
    check("lat_waddr", 32'(vram_waddr), 32'h0123);
    end_write();
    tick();
    tick();
    tick();
    check("stall_waddr", 32'(vram_waddr), 32'h0123);
    check("stall_wdata", 32'(vram_wdata), 32'h5A);
    vram_ack = 1'b1;
    tick();
    check("stall_pop_we", 32'(vram_we), 32'd0);
    check("stall_pop_count", 32'(n_xfer - n0), 32'd1);

    // Overflow: five writes while stalled, fifth dropped
    vram_ack = 1'b0;
    n0 = n_xfer;
    for (int i = 1; i <= 5; i++) begin
      write_op(16'h4000 + 16'(i), 8'(i), 1'b1, (i <= 4), 15'(i));
    end
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    drain("ovf_drain", n0, 4);
    check("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the same cycle as the push
    vram_ack = 1'b0;
    n0 = n_xfer;
    for (int i = 0; i < 4; i++) begin
      write_op(16'h4100 + 16'(i), 8'h10 + 8'(i), 1'b1, 1'b1, 15'h0100 + 15'(i));
    end
    check("fullpop_pre_level", 32'(level), 32'd4);
    expect_xfer(15'h0104, 8'h14);
    start_write(16'h4104, 8'h14, 1'b1);
    tick();
    vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    check("fullpop_level", 32'(level), 32'd4);
    check("fullpop_overflow", 32'(overflow), 32'd0);
    end_write();
    tick();
    tick();
    drain("fullpop_drain", n0, 5);

    // Reset mid-transfer flushes pending entries
    vram_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_op(16'h4200 + 16'(i), 8'h20 + 8'(i), 1'b1, 1'b1, 15'h0200 + 15'(i));
    end
    check("flush_pre_level", 32'(level), 32'd3);
    check("flush_pre_we", 32'(vram_we), 32'd1);
    reset = 1'b1;
    tick();
    check("flush_we", 32'(vram_we), 32'd0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_waddr", 32'(vram_waddr), 32'd0);
    sb.delete();

    // Strobe already active across reset release is not captured
    start_write(16'h4300, 8'h99, 1'b1);
    tick();
    reset = 1'b0;
    vram_ack = 1'b1;
    n0 = n_xfer;
    tick();
    tick();
    tick();
    end_write();
    for (int i = 0; i < 8; i++) tick();
    check("held_wr_xfers", 32'(n_xfer - n0), 32'd0);
    check("held_wr_level", 32'(level), 32'd0);

    // Still functional afterwards
    n0 = n_xfer;
    write_op(16'h4ABC, 8'hC3, 1'b1, 1'b1, 15'h0ABC);
    drain("post_reset", n0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
